poly_pitch_generator: RTL and testbench
=======================================

// Module: poly_pitch_generator
// PURPOSE
// - Polyphonic successor of the single-voice pitch generator: CHANNELS independent square-wave voices.
// - Each voice is written with a {note, octave} byte; one lookup FSM time-shares a single external
//   period ROM across all voices.
// - Outputs one square wave per voice plus a summed mix bus for the audio DAC/PWM stage.
// PARAMETERS
// - CHANNELS  4   number of voices (1..16)
// - PERIOD_W  32  width of ROM period word, in clk cycles per full wave period
// - CH_W      2   channel-select width; must satisfy 2**CH_W >= CHANNELS
// - MIX_W (localparam) = $clog2(3*CHANNELS+1), the mix-bus width
// PORTS
// - clk       in   1         system clock
// - rst       in   1         synchronous, active-high reset
// - we        in   1         write request; accepted only when we && ready
// - ch        in   CH_W      target voice for the write
// - data      in   8         {note[7:4], octave[3:0]}
//                            note 0 = silent, 1..12 = C..B; octave 0..9
// - vol       in   2         voice volume; used only with VOLUME_EN
// - ready     out  1         FSM idle, write can be accepted
// - rom_addr  out  7         period ROM address = (note-1)*10 + octave, range 0..119
// - rom_data  in   PERIOD_W  period ROM data; combinational ROM, valid in the same cycle
// - wave      out  CHANNELS  per-voice square wave
// - mix       out  MIX_W     sum of voice levels
// BEHAVIOUR
// - Reset:
//   - all voices disabled; per-voice period = 0, counter = 0.
//   - wave = 0, mix = 0, ready = 1, rom_addr = 0, FSM = IDLE.
// - FSM IDLE -> LOOKUP:
//   - taken on the edge where we && ready.
//   - ch/data/vol are latched; ready = 0 during LOOKUP.
// - FSM LOOKUP -> IDLE (always one cycle):
//   - rom_addr is driven from the latched data.
//   - At the end of the cycle, voice[ch] gets: period <= rom_data, counter <= 0, wave[ch] <= 0.
//   - en <= valid, where valid = note in 1..12 AND octave <= 9 AND rom_data >= 2.
// - Throughput: one write per 2 cycles. Write-to-first-toggle latency = 2 + period/2 cycles.
// - Invalid or silent data (note 0, note > 12, octave > 9):
//   - still takes the LOOKUP cycle; rom_addr is forced to 0; the voice is disabled.
// - ch >= CHANNELS: the write is accepted and consumed, with no voice change.
// - we while ready = 0: ignored, not queued. The writer must hold we until it sees ready.
// - Enabled voice:
//   - counter increments every clk.
//   - When counter == (period>>1) - 1: counter <= 0 and wave toggles.
//   - Odd periods truncate. Full period = 2*(period>>1) clk cycles.
// - Disabled voice: counter held at 0, wave held at 0.
// - Rewriting an active voice retriggers its phase; other voices are undisturbed.
// - mix: registered; mix = sum over i of (wave[i] ? level_i : 0). One cycle behind wave.
// - Reset asserted mid-LOOKUP: the pending write is dropped; the full reset state applies next cycle.
// CONFIGURATION
// - VOLUME_EN defined:
//   - vol is latched per voice on write; level_i = vol_i.
//   - vol = 0 mutes the voice in mix only; wave[i] still toggles.
// - VOLUME_EN undefined:
//   - the vol port is ignored (not stored); level_i = 3 for every voice.
// - MIX_W is unchanged in both cases.
// TESTING
// - Reset: assert rst 2 cycles -> wave=0, mix=0, ready=1, rom_addr=0.
// - Write ch=0, data=8'h14, ROM model returns 100:
//   - rom_addr=4 in the LOOKUP cycle.
//   - wave[0] toggles every 50 clks; first rise 52 clks after the accept edge.
// - Back-to-back we held high, ch=1 then ch=2:
//   - ready low exactly 1 cycle per write; both accepted 2 cycles apart.
//   - ch=0 wave phase is undisturbed.
// - data=8'h00, 8'hD3 (note 13) and 8'h1A (octave 10) -> the target voice goes silent, wave held 0.
// - ROM returns 1 -> voice disabled. ROM returns 3 -> toggles every 1 clk.
// - rst during LOOKUP for ch=3 -> voice 3 stays disabled; ready=1 after reset.
// - VOLUME_EN: voices 0/1 high with vol 2 and 3 -> mix=5. vol=0 -> mix excludes that voice.
// - Without VOLUME_EN: 4 voices high -> mix=12.

Source files
------------

// File: rtl/poly_pitch_generator.sv
// poly_pitch_generator
//   CHANNELS independent square-wave voices. Each voice is programmed with a
//   {note, octave} byte. A two-state lookup FSM shares one external,
//   combinational period ROM between all voices. A registered mix bus sums
//   the levels of the voices whose wave output is currently high.
//
// Optional feature macro: VOLUME_EN
//   defined   : vol is latched per voice on each write and is that voice's
//               mix level (0 mutes the voice in the mix only).
//   undefined : vol is ignored and every voice contributes level 3.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   we         in   write request, taken on an edge where we && ready
//   ch         in   target voice for the write
//   data       in   {note[7:4], octave[3:0]}; note 0 = silent, 1..12 = C..B
//   vol        in   voice volume (VOLUME_EN builds only)
//   ready      out  FSM idle, a write can be accepted
//   rom_addr   out  (note-1)*10 + octave during LOOKUP, otherwise 0
//   rom_data   in   period word for rom_addr, valid in the same cycle
//   wave       out  per-voice square wave
//   mix        out  registered sum of voice levels, one cycle behind wave
//   dbg_state  out  FSM state (0 = IDLE, 1 = LOOKUP)
//
// Handshake: a write is accepted on the rising edge where we && ready are
// both high. While ready is low, we is ignored and nothing is queued, so the
// writer holds we (and ch/data/vol) until it sees ready.
module poly_pitch_generator #(
    parameter  int CHANNELS = 4,
    parameter  int PERIOD_W = 32,
    parameter  int CH_W     = 2,
    localparam int MIX_W    = $clog2(3 * CHANNELS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [CH_W-1:0]     ch,
    input  logic [7:0]          data,
    input  logic [1:0]          vol,
    output logic                ready,
    output logic [6:0]          rom_addr,
    input  logic [PERIOD_W-1:0] rom_data,
    output logic [CHANNELS-1:0] wave,
    output logic [MIX_W-1:0]    mix,
    output logic [0:0]          dbg_state
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOOKUP = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [7:0]          data_q, data_d;

    logic [PERIOD_W-1:0] period_q [CHANNELS];
    logic [PERIOD_W-1:0] period_d [CHANNELS];
    logic [PERIOD_W-1:0] cnt_q    [CHANNELS];
    logic [PERIOD_W-1:0] cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] wave_q, wave_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [MIX_W-1:0]    mix_q, mix_d;

`ifdef VOLUME_EN
    logic [1:0]          vol_lat_q, vol_lat_d;
    logic [1:0]          voice_vol_q [CHANNELS];
    logic [1:0]          voice_vol_d [CHANNELS];
`else
    logic                unused_vol;
    assign unused_vol = ^vol;
`endif

    logic [3:0] note;
    logic [3:0] octave;
    logic       data_ok;
    logic       rom_ok;
    logic       lookup;

    assign note    = data_q[7:4];
    assign octave  = data_q[3:0];
    assign data_ok = (note >= 4'd1) && (note <= 4'd12) && (octave <= 4'd9);
    // A period below 2 has a zero half-period and could never toggle.
    assign rom_ok  = rom_data >= PERIOD_W'(2);
    assign lookup  = (state_q == ST_LOOKUP);

    assign ready     = (state_q == ST_IDLE);
    assign dbg_state = state_q;
    assign wave      = wave_q;
    assign mix       = mix_q;

    // Invalid data still spends the LOOKUP cycle but parks the ROM at 0.
    always_comb begin
        rom_addr = 7'd0;
        if (lookup && data_ok) begin
            rom_addr = 7'(note - 4'd1) * 7'd10 + 7'(octave);
        end
    end

    // Lookup FSM: IDLE accepts a write, LOOKUP always lasts one cycle.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        data_d  = data_q;
`ifdef VOLUME_EN
        vol_lat_d = vol_lat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (we) begin
                    state_d = ST_LOOKUP;
                    ch_d    = ch;
                    data_d  = data;
`ifdef VOLUME_EN
                    vol_lat_d = vol;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Voice counters plus write-back at the end of LOOKUP. A channel index
    // with no matching voice matches nothing, so that write is simply consumed.
    always_comb begin
        wave_d = wave_q;
        en_d   = en_q;
        for (int i = 0; i < CHANNELS; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
`ifdef VOLUME_EN
            voice_vol_d[i] = voice_vol_q[i];
`endif
            if (en_q[i]) begin
                if (cnt_q[i] == (period_q[i] >> 1) - PERIOD_W'(1)) begin
                    cnt_d[i]  = '0;
                    wave_d[i] = ~wave_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                end
            end else begin
                cnt_d[i]  = '0;
                wave_d[i] = 1'b0;
            end

            if (lookup && (ch_q == CH_W'(i))) begin
                period_d[i] = rom_data;
                cnt_d[i]    = '0;
                wave_d[i]   = 1'b0;
                en_d[i]     = data_ok && rom_ok;
`ifdef VOLUME_EN
                voice_vol_d[i] = vol_lat_q;
`endif
            end
        end
    end

    // Mix is built from the registered waves, hence one cycle behind them.
    always_comb begin
        mix_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wave_q[i]) begin
`ifdef VOLUME_EN
                mix_d = mix_d + MIX_W'(voice_vol_q[i]);
`else
                mix_d = mix_d + MIX_W'(2'd3);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            data_q  <= '0;
            wave_q  <= '0;
            en_q    <= '0;
            mix_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
`ifdef VOLUME_EN
                voice_vol_q[i] <= '0;
`endif
            end
`ifdef VOLUME_EN
            vol_lat_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            wave_q  <= wave_d;
            en_q    <= en_d;
            mix_q   <= mix_d;
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
`ifdef VOLUME_EN
                voice_vol_q[i] <= voice_vol_d[i];
`endif
            end
`ifdef VOLUME_EN
            vol_lat_q <= vol_lat_d;
`endif
        end
    end

endmodule

// File: tb/tb_poly_pitch_generator.sv
// Directed bench for poly_pitch_generator (CHANNELS=4, PERIOD_W=32, CH_W=2).
// Expected waves come from a closed-form model: a voice written on edge W
// with half-period h is high after edge t when ((t-W)/h) is odd.
module tb_poly_pitch_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  ch;
    logic [7:0]  data;
    logic [1:0]  vol;
    logic        ready;
    logic [6:0]  rom_addr;
    logic [31:0] rom_data;
    logic [3:0]  wave;
    logic [3:0]  mix;
    logic [0:0]  dbg_state;

    logic [31:0] rom_tbl [128];
    assign rom_data = rom_tbl[rom_addr];

    poly_pitch_generator dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .ch        (ch),
        .data      (data),
        .vol       (vol),
        .ready     (ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .wave      (wave),
        .mix       (mix),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // model state per voice
    logic       en_m   [4];
    int         w_edge [4];
    int         half_m [4];
    int         lvl_m  [4];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [3:0] exp_wave_at(input int t);
        logic [3:0] w;
        w = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (en_m[i] && t >= w_edge[i]) w[i] = (((t - w_edge[i]) / half_m[i]) % 2) == 1;
        end
        return w;
    endfunction

    function automatic int exp_mix_at(input int t);
        logic [3:0] w;
        int s;
        w = exp_wave_at(t - 1);
        s = 0;
        for (int i = 0; i < 4; i++) if (w[i]) s += lvl_m[i];
        return s;
    endfunction

    task automatic set_model(input int c, input int w, input logic en, input int h, input logic [1:0] v);
        w_edge[c] = w;
        en_m[c]   = en;
        half_m[c] = h;
`ifdef VOLUME_EN
        lvl_m[c]  = int'(v);
`else
        lvl_m[c]  = 3;
`endif
    endtask

    // Issue one write and check the LOOKUP cycle; write-back edge is accept+1.
    task automatic do_write(input int c, input logic [7:0] d, input logic [1:0] v,
                            input logic [6:0] exp_addr, input logic exp_en, input int exp_half);
        int n;
        we = 1'b1; ch = 2'(c); data = d; vol = v;
        n = 0;
        while (!ready && n < 10) begin
            tick();
            n++;
        end
        check("wr_ready", ready, 1);
        tick();
        we = 1'b0;
        check("lookup_ready", ready, 0);
        check("lookup_addr", rom_addr, exp_addr);
        check("lookup_state", dbg_state, 1);
        set_model(c, cyc + 1, exp_en, exp_half, v);
    endtask

    task automatic check_voices(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check("wave", wave, exp_wave_at(cyc));
            check("mix", mix, exp_mix_at(cyc));
            check("idle_ready", ready, 1);
        end
    endtask

    initial begin
        int lat;
        int n;
        int found;
        int exp_all;

        for (int i = 0; i < 128; i++) rom_tbl[i] = 32'd40;
        rom_tbl[4]   = 32'd100;  // 8'h14
        rom_tbl[13]  = 32'd20;   // 8'h23
        rom_tbl[25]  = 32'd30;   // 8'h35
        rom_tbl[35]  = 32'd3;    // 8'h45
        rom_tbl[119] = 32'd1;    // 8'hC9
        for (int i = 0; i < 4; i++) begin
            en_m[i] = 1'b0; w_edge[i] = 0; half_m[i] = 1; lvl_m[i] = 3;
        end

        // reset
        rst = 1'b1; we = 1'b0; ch = 2'd0; data = 8'h00; vol = 2'd0;
        tick();
        tick();
        check("rst_wave", wave, 0);
        check("rst_mix", mix, 0);
        check("rst_ready", ready, 1);
        check("rst_addr", rom_addr, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        tick();

        // ch0 <- 8'h14, period 100: first rise 52 edges counting the accept edge
        do_write(0, 8'h14, 2'd2, 7'd4, 1'b1, 50);
        lat = 1;
        while (wave[0] == 1'b0 && lat < 200) begin
            tick();
            lat++;
        end
        check("first_rise_latency", lat, 52);
        check("mix_lags_wave", mix, 0);
        tick();
        check("mix_one_voice", mix, 3'd3 == 3 ? exp_mix_at(cyc) : 0);
        n = 1;
        while (wave[0] == 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("high_time", n, 50);

        // back-to-back, we held high: ch1 <- 8'h23 then ch2 <- 8'h35
        we = 1'b1; ch = 2'd1; data = 8'h23; vol = 2'd3;
        tick();
        check("b2b_lookup1_ready", ready, 0);
        check("b2b_lookup1_addr", rom_addr, 13);
        ch = 2'd2; data = 8'h35; vol = 2'd0;
        tick();
        set_model(1, cyc, 1'b1, 10, 2'd3);
        check("b2b_ready_back", ready, 1);
        tick();
        check("b2b_lookup2_ready", ready, 0);
        check("b2b_lookup2_addr", rom_addr, 25);
        we = 1'b0;
        tick();
        set_model(2, cyc, 1'b1, 15, 2'd0);
        check("b2b_idle", ready, 1);
        check_voices(60);

        // ch3 <- 8'h45, period 3: toggles every clock
        do_write(3, 8'h45, 2'd1, 7'd35, 1'b1, 1);
        tick();
        check_voices(6);

        // all four voices high -> full mix
`ifdef VOLUME_EN
        exp_all = 6;   // vols 2 + 3 + 0 + 1
`else
        exp_all = 12;
`endif
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            tick();
            if (exp_wave_at(cyc - 1) == 4'hF) begin
                check("mix_all_high", mix, exp_all);
                found = 1;
            end
        end
        check("all_high_seen", found, 1);

        // ROM returns 1 -> voice disabled; also top ROM address
        do_write(2, 8'hC9, 2'd2, 7'd119, 1'b0, 1);
        tick();
        check_voices(40);

        // invalid / silent data: address forced to 0 even though rom[0] is valid
        do_write(1, 8'h00, 2'd1, 7'd0, 1'b0, 1);
        do_write(3, 8'hD3, 2'd1, 7'd0, 1'b0, 1);
        do_write(0, 8'h1A, 2'd1, 7'd0, 1'b0, 1);
        tick();
        check_voices(30);

        // reset during LOOKUP for ch3 with ch0 running
        do_write(0, 8'h45, 2'd3, 7'd35, 1'b1, 1);
        tick();
        check_voices(4);
        do_write(3, 8'h45, 2'd3, 7'd35, 1'b1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) en_m[i] = 1'b0;
        check("midrst_ready", ready, 1);
        check("midrst_state", dbg_state, 0);
        check("midrst_wave", wave, 0);
        check("midrst_mix", mix, 0);
        check("midrst_addr", rom_addr, 0);
        check_voices(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
